bus_timer: RTL
==============

Name: bus_timer

Overview:
- Programmable countdown timer that acts as a responder on the CPU's processor bus (the PrAddr/PrDOut/Wen/PrDIn/HWInt bridge).
- The CPU reads and writes three word registers: CTRL, PRESET and COUNT.
- The timer decrements COUNT from PRESET and raises an interrupt line that is wired into one HWInt bit of the CPU's CP0.
- It is the first device on the bridge and the device end of that processor interface.

Parameters:
- PRESCALE, 1: clock cycles per COUNT decrement; legal range 1..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- sel  in  1  device select, decoded by the bridge from PrAddr.
- addr  in  2  word offset, PrAddr[3:2].
- we  in  1  write enable (CPU Wen qualified by sel).
- din  in  32  write data (CPU PrDOut).
- dout  out  32  read data (to bridge, feeds CPU PrDIn).
- irq  out  1  interrupt request (to CP0 HWInt bit).

Behaviour:
- Register map, by addr value:
  - 0 CTRL, R/W: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask).
  - 1 PRESET, R/W, 32 bits.
  - 2 COUNT, read-only.
  - 3 reserved: reads 0, writes ignored.
- Reset (rst=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, pending=0, state IDLE, prescaler=0, irq=0.
- dout is combinational from addr and independent of sel:
  - CTRL reads as {28'b0, CTRL[3:0]}.
  - PRESET and COUNT read unmodified.
  - addr 3 reads 0.
- Write: when sel&we at a clock edge, CTRL takes din[3:0], or PRESET takes din. A write to COUNT or reserved has no effect.
- Interrupt output: irq = pending & IM, registered-source and glitch-free.
- FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: COUNT holds. If EN=1, go to LOAD.
  - LOAD: COUNT<=PRESET, prescaler<=0, go to CNT.
  - CNT: if EN=0, go to IDLE (COUNT frozen). Else if COUNT==0, go to INT and set pending. Else on each prescaler tick (every PRESCALE cycles), COUNT<=COUNT-1.
  - INT, MODE=01: clear pending (1-cycle pulse), go to LOAD.
  - INT, other MODE: clear EN, go to IDLE. pending stays 1 until the next CPU write to CTRL or PRESET.
- Latency, with PRESCALE=1 and PRESET=N:
  - Edge of the CTRL write (EN=1) = edge 0.
  - State LOAD after edge 1; COUNT=N after edge 2.
  - COUNT=0 after edge N+2; INT and pending=1 after edge N+3.
  - Auto-reload period is N+3 cycles.
- Boundaries:
  - PRESET=0: INT is reached on the first CNT cycle.
  - A PRESET write during CNT affects only the next LOAD.
  - Clearing EN mid-count freezes COUNT. Re-enabling restarts from PRESET via LOAD (no resume).
- Simultaneous events:
  - A bus write to CTRL/PRESET in the same cycle as a CNT->INT transition has priority: pending stays 0.
  - A CTRL write at that edge defines EN and MODE for the following cycle.
  - If the INT-state EN clear coincides with a CTRL write, the written value wins.
- Reset asserted mid-count returns everything to reset values immediately. No interrupt is generated.
- COUNT never wraps below 0.

Decomposition:
- Shared include macro.v gains:
  - TIMER_ADDR_CTRL/PRESET/COUNT offsets.
  - CTRL bit positions (EN, MODE, IM).
  - MODE encodings.
  - FSM state encodings S_TIMER_IDLE/LOAD/CNT/INT.
- One sub-module, timer_prescaler:
  - Cycle counter with synchronous clear (from LOAD).
  - Outputs a 1-cycle tick every PRESCALE cycles; tick is constant 1 when PRESCALE=1.

Test Plan:
- Reset/readback: assert rst=0 mid-run -> all reads 0, irq=0. Write PRESET=32'h1234_5678 -> read addr1 = 32'h1234_5678. Write COUNT -> read still 0.
- One-shot: PRESET=5, CTRL=4'b1001 -> COUNT steps 5..0, irq rises exactly 8 cycles after the write edge. EN reads 0; irq stays 1 until CTRL is rewritten, then irq=0 the next cycle.
- Auto-reload: PRESET=3, CTRL=4'b1011 -> irq 1-cycle pulses every 6 cycles, at least 3 periods.
- Mask/pause: IM=0 -> pending set but irq=0. Clear EN at COUNT=7 -> COUNT frozen at 7. Set EN -> COUNT reloads PRESET.
- Corners: PRESET=0 one-shot -> irq 3 cycles after enable. CTRL write coinciding with the CNT->INT edge -> irq stays 0.
- PRESCALE=4 build: PRESET=2 -> COUNT decrements every 4 cycles, irq 11 cycles after the enable edge.

Source files
------------

// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus timer: register offsets, CTRL bit positions,
// MODE encodings and FSM state encodings.
package bus_timer_pkg;

    // Word offsets on the processor bus (PrAddr[3:2])
    localparam logic [1:0] TIMER_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_ADDR_PRESET = 2'd1;
    localparam logic [1:0] TIMER_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] TIMER_ADDR_RSVD   = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE encodings; 00 and 1x both behave as one-shot
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    // FSM state encodings
    localparam logic [1:0] S_TIMER_IDLE = 2'd0;
    localparam logic [1:0] S_TIMER_LOAD = 2'd1;
    localparam logic [1:0] S_TIMER_CNT  = 2'd2;
    localparam logic [1:0] S_TIMER_INT  = 2'd3;

    // Prescaler counter width, enough for PRESCALE up to 65535
    localparam int PRESCALE_W = 16;

    // Only the exact 01 encoding selects auto-reload
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Processor-bus responder port of the timer.
// Handshake: there is no valid/ready pair. A write is a single-cycle event,
// accepted at the rising edge where sel & we are both high; the device never
// stalls. Reads are combinational: dout follows addr at all times, and the
// bridge samples it when it selects the device.
interface bus_timer_if;
    import bus_timer_pkg::*;

    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output sel, output addr, output we, output din,
                    input dout, input irq);
    modport slave  (input sel, input addr, input we, input din,
                    output dout, output irq);
endinterface

// File: rtl/bus_timer_prescaler.sv
// Prescaler for the bus timer: emits a one-cycle tick every PRESCALE cycles.
// With PRESCALE=1 the counter stays at 0 and the tick is permanently high.
module timer_prescaler
    import bus_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_cnt;

    // Free-running cycle counter, wrapped at PRESCALE-1, cleared on LOAD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tick on the last cycle of each prescale period
    always_comb begin
        o_tick = (r_cnt == LAST);
    end

endmodule

// File: rtl/bus_timer.sv
// Programmable countdown timer on the processor bus. COUNT is loaded from
// PRESET and decremented once per prescaler tick; reaching zero latches a
// pending flag, which drives irq through the IM mask.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    bus_timer_if.slave  bus,
    output logic [1:0]  o_dbg_state
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pending;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_wr_any;
    logic        w_tick;
    logic        w_load;
    logic        w_en;
    logic        w_reload;
    logic        w_cnt_zero;

    // Bus write decode and FSM helper terms
    always_comb begin
        w_wr_ctrl   = bus.sel && bus.we && (bus.addr == TIMER_ADDR_CTRL);
        w_wr_preset = bus.sel && bus.we && (bus.addr == TIMER_ADDR_PRESET);
        w_wr_any    = w_wr_ctrl || w_wr_preset;
        w_load      = (r_state == S_TIMER_LOAD);
        w_en        = r_ctrl[CTRL_EN];
        w_reload    = is_reload(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);
        w_cnt_zero  = (r_count == 32'd0);
    end

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_load),
        .o_tick  (w_tick)
    );

    // Next-state logic of the IDLE/LOAD/CNT/INT sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_TIMER_IDLE: if (w_en) w_state_nxt = S_TIMER_LOAD;
            S_TIMER_LOAD: w_state_nxt = S_TIMER_CNT;
            S_TIMER_CNT: begin
                if (!w_en) begin
                    w_state_nxt = S_TIMER_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_TIMER_INT;
                end
            end
            S_TIMER_INT: w_state_nxt = w_reload ? S_TIMER_LOAD : S_TIMER_IDLE;
            default: w_state_nxt = S_TIMER_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_TIMER_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // CTRL: a bus write always wins over the one-shot EN clear in INT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl <= 4'd0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= bus.din[3:0];
        end else if ((r_state == S_TIMER_INT) && !w_reload) begin
            r_ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // PRESET: only sampled by LOAD, so mid-count writes affect the next load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_preset <= 32'd0;
        end else if (w_wr_preset) begin
            r_preset <= bus.din;
        end
    end

    // COUNT: load in LOAD, decrement on ticks in CNT, never below zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 32'd0;
        end else if (w_load) begin
            r_count <= r_preset;
        end else if ((r_state == S_TIMER_CNT) && w_en && !w_cnt_zero && w_tick) begin
            r_count <= r_count - 32'd1;
        end
    end

    // Pending: a CPU write to CTRL/PRESET clears it and blocks a same-cycle set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
        end else if (w_wr_any) begin
            r_pending <= 1'b0;
        end else if ((r_state == S_TIMER_CNT) && w_en && w_cnt_zero) begin
            r_pending <= 1'b1;
        end else if ((r_state == S_TIMER_INT) && w_reload) begin
            r_pending <= 1'b0;
        end
    end

    // Read mux, independent of sel; irq is an AND of two flops
    always_comb begin
        case (bus.addr)
            TIMER_ADDR_CTRL:   bus.dout = {28'd0, r_ctrl};
            TIMER_ADDR_PRESET: bus.dout = r_preset;
            TIMER_ADDR_COUNT:  bus.dout = r_count;
            TIMER_ADDR_RSVD:   bus.dout = 32'd0;
            default:           bus.dout = 32'd0;
        endcase
        bus.irq     = r_pending && r_ctrl[CTRL_IM];
        o_dbg_state = r_state;
    end

endmodule
